// File: rtl/sm_tc_conv_pipe_pkg.sv
// Shared definitions for the sign-magnitude / two's-complement converter pipe.
// Payload fields are sized for the widest legal word; users take the low WIDTH bits.
package sm_tc_pkg;

    localparam int MAX_W = 64;

    localparam logic MODE_SM2TC = 1'b0;
    localparam logic MODE_TC2SM = 1'b1;

    // Stage 1 payload: the raw word, its conversion controls and its negation.
    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic             mode;
        logic             sat;
        logic [MAX_W-1:0] neg;
    } stage_payload_t;

    // Stage 2 payload: the formatted result and its flags.
    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic             ovf;
        logic             negzero;
    } result_t;

endpackage

// File: rtl/sm_tc_conv_pipe_if.sv
// Streaming input/output bundle of the converter pipe.
interface sm_tc_conv_pipe_if #(
    parameter int WIDTH = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_negzero;

    // Producer/consumer side that drives words in and takes results out.
    modport master (
        output in_valid, in_data, in_mode, in_sat, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_negzero
    );

    // The converter itself.
    modport slave (
        input  in_valid, in_data, in_mode, in_sat, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_negzero
    );
endinterface

// File: rtl/sm_tc_pipe_stage.sv
// One valid/ready register slice; accepts when empty or when its word leaves.
module sm_tc_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    assign in_ready = !out_valid || out_ready;

    // Load a new word (or go empty) whenever the current one can move on.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            // NOTE: the data register is reset too, so outputs read zero after reset.
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/sm_tc_conv_pipe.sv
// Two-stage SM <-> two's-complement converter with overflow event counter.
module sm_tc_conv_pipe
    import sm_tc_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    sm_tc_conv_pipe_if.slave  bus,
    input  logic              ovf_clr,
    output logic [CNT_W-1:0]  ovf_count
);
    stage_payload_t   s1_d, s1_q;
    result_t          s2_d, s2_q;
    logic             s1_valid;
    logic             s2_ready;
    logic [WIDTH-1:0] in_neg;
    logic [WIDTH-1:0] w, n, res_w;
    logic             res_ovf, res_nz;
    logic             ovf_hit;
    logic             unused_bits;

    assign in_neg = ~bus.in_data + WIDTH'(1);

    // Package the incoming word together with its negation for stage 1.
    always_comb begin
        s1_d      = '0;
        s1_d.data = MAX_W'(bus.in_data);
        s1_d.mode = bus.in_mode;
        s1_d.sat  = bus.in_sat;
        s1_d.neg  = MAX_W'(in_neg);
    end

    sm_tc_pipe_stage #(.W($bits(stage_payload_t))) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    assign w = s1_q.data[WIDTH-1:0];
    assign n = s1_q.neg[WIDTH-1:0];

    // Format the result: both directions share the negate-the-value-bits path;
    // only an all-zero value field with the sign set needs special handling.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        res_w   = w;
        res_ovf = 1'b0;
        res_nz  = 1'b0;
        if (w[WIDTH-1]) begin
            if (|w[WIDTH-2:0]) begin
                res_w = {1'b1, n[WIDTH-2:0]};
            end else if (s1_q.mode == MODE_TC2SM) begin
                res_ovf = 1'b1;
                res_w   = s1_q.sat ? '1 : w;
            end else begin
                res_w  = '0;
                res_nz = 1'b1;
            end
        end
        s2_d         = '0;
        s2_d.data    = MAX_W'(res_w);
        s2_d.ovf     = res_ovf;
        s2_d.negzero = res_nz;
    end

    sm_tc_pipe_stage #(.W($bits(result_t))) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_d),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_q)
    );

    assign bus.out_data    = s2_q.data[WIDTH-1:0];
    assign bus.out_ovf     = s2_q.ovf;
    assign bus.out_negzero = s2_q.negzero;

    // Payload fields wider than WIDTH carry no information.
    assign unused_bits = ^{s1_q, s2_q};

    assign ovf_hit = bus.out_valid && bus.out_ready && s2_q.ovf;

    // Count delivered overflow results, saturating; a clear still counts a same-cycle hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= CNT_W'(ovf_hit);
        end else if (ovf_hit && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sm_tc_conv_pipe.sv
// Directed, table-driven bench for the SM <-> two's-complement converter pipe.
module tb_sm_tc_conv_pipe;
    import sm_tc_pkg::*;

    localparam int WIDTH = 11;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ovf_clr = 1'b0;
    logic [CNT_W-1:0] ovf_count;

    always #5 clk = ~clk;

    sm_tc_conv_pipe_if #(.WIDTH(WIDTH)) bus ();

    sm_tc_conv_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
    );

    typedef struct {
        logic             mode;
        logic             sat;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dout;
        logic             ovf;
        logic             nz;
    } vec_t;

    vec_t vecs [14];
    int   sidx [6] = '{0, 3, 2, 1, 4, 7};
    int   stl  [3] = '{5, 0, 9};
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_data  = v.din;
        bus.in_mode  = v.mode;
        bus.in_sat   = v.sat;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, "_data"},    bus.out_data,    v.dout);
        check({tag, "_ovf"},     bus.out_ovf,     v.ovf);
        check({tag, "_negzero"}, bus.out_negzero, v.nz);
    endtask

    initial begin
        int  tx, rx, n, first, last, seen;
        logic acc;

        //            mode        sat   din      dout     ovf   nz
        vecs[0]  = '{MODE_SM2TC, 1'b0, 11'h405, 11'h7FB, 1'b0, 1'b0};
        vecs[1]  = '{MODE_SM2TC, 1'b0, 11'h400, 11'h000, 1'b0, 1'b1};
        vecs[2]  = '{MODE_TC2SM, 1'b0, 11'h7FB, 11'h405, 1'b0, 1'b0};
        vecs[3]  = '{MODE_TC2SM, 1'b0, 11'h400, 11'h400, 1'b1, 1'b0};
        vecs[4]  = '{MODE_TC2SM, 1'b1, 11'h400, 11'h7FF, 1'b1, 1'b0};
        vecs[5]  = '{MODE_SM2TC, 1'b0, 11'h123, 11'h123, 1'b0, 1'b0};
        vecs[6]  = '{MODE_TC2SM, 1'b0, 11'h3FF, 11'h3FF, 1'b0, 1'b0};
        vecs[7]  = '{MODE_SM2TC, 1'b0, 11'h7FF, 11'h401, 1'b0, 1'b0};
        vecs[8]  = '{MODE_TC2SM, 1'b0, 11'h401, 11'h7FF, 1'b0, 1'b0};
        vecs[9]  = '{MODE_TC2SM, 1'b0, 11'h7FF, 11'h401, 1'b0, 1'b0};
        vecs[10] = '{MODE_SM2TC, 1'b0, 11'h000, 11'h000, 1'b0, 1'b0};
        vecs[11] = '{MODE_TC2SM, 1'b1, 11'h000, 11'h000, 1'b0, 1'b0};
        vecs[12] = '{MODE_SM2TC, 1'b1, 11'h400, 11'h000, 1'b0, 1'b1};
        vecs[13] = '{MODE_SM2TC, 1'b1, 11'h401, 11'h7FF, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.in_sat    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",   bus.out_valid,   0);
        check("rst_out_data",    bus.out_data,    0);
        check("rst_out_ovf",     bus.out_ovf,     0);
        check("rst_out_negzero", bus.out_negzero, 0);
        check("rst_ovf_count",   ovf_count,       0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        // One word at a time: exact two-cycle latency and value per vector
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i]);
            n = 0;
            while (!bus.in_ready && n < 10) begin
                tick();
                n++;
            end
            if (n >= 10) check("vec_in_ready_timeout", bus.in_ready, 1);
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), bus.out_valid, 0);
            tick();
            check($sformatf("vec%0d_lat2_valid", i), bus.out_valid, 1);
            check_out($sformatf("vec%0d", i), vecs[i]);
            tick();
        end
        check("table_ovf_count", ovf_count, 2);

        // Clear alone goes to zero
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_alone_ovf_count", ovf_count, 0);

        // Back-to-back mixed stream
        tx = 0; rx = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.out_valid) begin
                if (rx < 6) check_out($sformatf("stream%0d", rx), vecs[sidx[rx]]);
                if (rx == 0) first = cyc;
                last = cyc;
                rx++;
            end
            if (tx < 6) drive(vecs[sidx[tx]]);
            else bus.in_valid = 1'b0;
            #1;
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) tx++;
        end
        bus.in_valid = 1'b0;
        check("stream_count", rx, 6);
        check("stream_consecutive", last - first, 5);

        // Backpressure: 3 words offered during a 5-cycle stall
        bus.out_ready = 1'b0;
        tx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (tx < 3) drive(vecs[stl[tx]]);
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) check_out($sformatf("hold_c%0d", cyc), vecs[stl[0]]);
            tick();
            if (acc) tx++;
        end
        check("stall_accepted", tx, 2);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        check_out("stall_held", vecs[stl[0]]);
        bus.out_ready = 1'b1;
        rx = 0;
        for (int cyc = 0; cyc < 15 && rx < 3; cyc++) begin
            if (tx < 3) drive(vecs[stl[tx]]);
            else bus.in_valid = 1'b0;
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check_out($sformatf("drain%0d", rx), vecs[stl[rx]]);
                rx++;
            end
            tick();
            if (acc) tx++;
        end
        bus.in_valid = 1'b0;
        check("drain_count", rx, 3);

        // Overflow counter saturation
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tx = 0; rx = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (bus.out_valid) rx++;
            if (tx < 5) drive(vecs[3]);
            else bus.in_valid = 1'b0;
            #1;
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) tx++;
        end
        bus.in_valid = 1'b0;
        check("ovf_delivered", rx, 5);
        check("ovf_count_sat", ovf_count, 3);

        // Clear concurrent with an overflow transfer
        drive(vecs[4]);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        check("clr_inc_out_valid", bus.out_valid, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_inc_ovf_count", ovf_count, 1);

        // Reset with two words in flight
        bus.out_ready = 1'b0;
        drive(vecs[3]);
        tick();
        drive(vecs[4]);
        tick();
        bus.in_valid = 1'b0;
        check("inflight_out_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data",  bus.out_data,  0);
        check("midrst_ovf_count", ovf_count,     0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("postrst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("postrst_no_output", seen, 0);
        check("postrst_ovf_count", ovf_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
